// File: rtl/pmem_boot_loader_pkg.sv
// Shared constants and FSM encoding for the swt16 serial program loader.
// Module parameters default to these values.
package pmem_boot_loader_pkg;

   localparam int DEF_PMEM_ADDR_WIDTH = 12;
   localparam int DEF_PMEM_WORD_WIDTH = 16;
   localparam int DEF_PMEM_NUM_WORDS  = 2048;
   localparam int DEF_PC_INCREMENT    = 2;
   localparam int STATE_WIDTH         = 3;

   typedef enum logic [STATE_WIDTH-1:0] {
      S_CNT_LO  = 3'd0,
      S_CNT_HI  = 3'd1,
      S_DATA_LO = 3'd2,
      S_DATA_HI = 3'd3,
      S_CSUM    = 3'd4,
      S_RUN     = 3'd5,
      S_ERROR   = 3'd6
   } state_e;

endpackage

// File: rtl/pmem_boot_loader.sv
// Frame parser that loads 16-bit words into PMEM and holds the core in reset
// until a frame with a matching XOR checksum has arrived.
module pmem_boot_loader
   import pmem_boot_loader_pkg::*;
#(
   parameter int PMEM_ADDR_WIDTH = DEF_PMEM_ADDR_WIDTH,
   parameter int PMEM_WORD_WIDTH = DEF_PMEM_WORD_WIDTH,
   parameter int PMEM_NUM_WORDS  = DEF_PMEM_NUM_WORDS,
   parameter int PC_INCREMENT    = DEF_PC_INCREMENT
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_byte_valid,
   input  logic [7:0]                 in_byte,
   output logic                       out_byte_ready,
   output logic                       out_pmem_wr_en,
   output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_wr_addr,
   output logic [PMEM_WORD_WIDTH-1:0] out_pmem_wr_word,
   output logic                       out_core_reset,
   output logic                       out_done,
   output logic                       out_error,
   output logic [STATE_WIDTH-1:0]     out_dbg_state
);

   localparam int IDX_WIDTH = $clog2(PMEM_NUM_WORDS) + 1;

   // Handshake: a byte moves on a rising edge when in_byte_valid && out_byte_ready;
   // ready depends on the state register only, never on in_byte_valid.
   state_e                     state_q, state_d;
   logic [15:0]                cnt_q, cnt_d;
   logic [IDX_WIDTH-1:0]       idx_q, idx_d;
   logic [7:0]                 lo_q, lo_d;
   logic [7:0]                 acc_q, acc_d;
   logic                       wr_en_q, wr_en_d;
   logic [PMEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [PMEM_WORD_WIDTH-1:0] wr_word_q, wr_word_d;
   logic                       done_q, done_d;
   logic                       error_q, error_d;
   logic                       core_reset_q, core_reset_d;
   logic                       xfer;

   assign out_byte_ready = (state_q != S_RUN) && (state_q != S_ERROR);
   assign xfer           = in_byte_valid && out_byte_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      lo_d      = lo_q;
      acc_d     = acc_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_word_d = wr_word_q;
      if (xfer) begin
         case (state_q)
            S_CNT_LO: begin
               cnt_d   = {8'h00, in_byte};
               state_d = S_CNT_HI;
            end
            S_CNT_HI: begin
               cnt_d = {in_byte, cnt_q[7:0]};
               if (cnt_d == 16'd0)                        state_d = S_CSUM;
               else if (cnt_d > 16'(PMEM_NUM_WORDS))      state_d = S_ERROR;
               else                                       state_d = S_DATA_LO;
            end
            S_DATA_LO: begin
               lo_d    = in_byte;
               acc_d   = acc_q ^ in_byte;
               state_d = S_DATA_HI;
            end
            S_DATA_HI: begin
               acc_d     = acc_q ^ in_byte;
               wr_en_d   = 1'b1;
               wr_word_d = PMEM_WORD_WIDTH'({in_byte, lo_q});
               wr_addr_d = PMEM_ADDR_WIDTH'(idx_q * PC_INCREMENT);
               idx_d     = idx_q + 1'b1;
               state_d   = (16'(idx_d) < cnt_q) ? S_DATA_LO : S_CSUM;
            end
            S_CSUM:  state_d = (in_byte == acc_q) ? S_RUN : S_ERROR;
            default: state_d = state_q;
         endcase
      end
      // Status outputs are registered copies of where the FSM is heading.
      done_d       = (state_d == S_RUN);
      error_d      = (state_d == S_ERROR);
      core_reset_d = (state_d != S_RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_CNT_LO;
         cnt_q        <= '0;
         idx_q        <= '0;
         lo_q         <= '0;
         acc_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_word_q    <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         core_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         lo_q         <= lo_d;
         acc_q        <= acc_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_word_q    <= wr_word_d;
         done_q       <= done_d;
         error_q      <= error_d;
         core_reset_q <= core_reset_d;
      end
   end

   assign out_pmem_wr_en   = wr_en_q;
   assign out_pmem_wr_addr = wr_addr_q;
   assign out_pmem_wr_word = wr_word_q;
   assign out_done         = done_q;
   assign out_error        = error_q;
   assign out_core_reset   = core_reset_q;
   assign out_dbg_state    = state_q;

endmodule

// File: tb/tb_pmem_boot_loader.sv
// Directed bench for pmem_boot_loader: a frame-level model predicts PMEM writes
// and final status; a negedge monitor compares the DUT every cycle.
module tb_pmem_boot_loader;

   localparam int ST_LOAD = 0;
   localparam int ST_RUN  = 1;
   localparam int ST_ERR  = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_byte_valid;
   logic [7:0]  in_byte;
   logic        out_byte_ready;
   logic        out_pmem_wr_en;
   logic [11:0] out_pmem_wr_addr;
   logic [15:0] out_pmem_wr_word;
   logic        out_core_reset;
   logic        out_done;
   logic        out_error;
   logic [2:0]  out_dbg_state;

   pmem_boot_loader dut (
      .clock            (clock),
      .reset            (reset),
      .in_byte_valid    (in_byte_valid),
      .in_byte          (in_byte),
      .out_byte_ready   (out_byte_ready),
      .out_pmem_wr_en   (out_pmem_wr_en),
      .out_pmem_wr_addr (out_pmem_wr_addr),
      .out_pmem_wr_word (out_pmem_wr_word),
      .out_core_reset   (out_core_reset),
      .out_done         (out_done),
      .out_error        (out_error),
      .out_dbg_state    (out_dbg_state)
   );

   always #5 clock = ~clock;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [27:0] exp_q[$];
   logic [7:0]  frame_q[$];
   logic [15:0] wq[$];
   int          exp_status;
   int          exp_final;
   logic [7:0]  model_csum;
   bit          chk_en = 1'b0;
   int          strobes;
   logic [11:0] last_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Frame model: bytes to send, PMEM writes that must appear, final status.
   task automatic build_frame(input int n, input bit bad_csum);
      logic [15:0] w;
      frame_q.delete();
      exp_q.delete();
      frame_q.push_back(8'(n));
      frame_q.push_back(8'(n >> 8));
      model_csum = 8'h00;
      if (n > 2048) begin
         exp_final = ST_ERR;
         return;
      end
      for (int i = 0; i < n; i++) begin
         w = wq[i];
         frame_q.push_back(w[7:0]);
         frame_q.push_back(w[15:8]);
         model_csum = model_csum ^ w[7:0] ^ w[15:8];
         exp_q.push_back({12'(i * 2), w});
      end
      frame_q.push_back(bad_csum ? (model_csum ^ 8'h01) : model_csum);
      exp_final = bad_csum ? ST_ERR : ST_RUN;
   endtask

   // Runs at posedge+2. Sends the first `count` frame bytes with 0..max_gap idle cycles each.
   task automatic send_bytes(input int count, input int max_gap);
      int t;
      for (int i = 0; i < count; i++) begin
         in_byte_valid = 1'b0;
         repeat ($urandom_range(0, max_gap)) begin
            @(posedge clock);
            #2;
         end
         in_byte_valid = 1'b1;
         in_byte       = frame_q[i];
         t = 0;
         while (!out_byte_ready && t < 20) begin
            @(posedge clock);
            #2;
            t++;
         end
         if (t == 20) check("ready_timeout", 32'(out_byte_ready), 32'd1);
         @(posedge clock);
         #2;
         if (i == frame_q.size() - 1) exp_status = exp_final;
      end
      in_byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      chk_en        = 1'b0;
      reset         = 1'b1;
      in_byte_valid = 1'b0;
      in_byte       = 8'h00;
      repeat (2) begin
         @(posedge clock);
         #2;
      end
      reset      = 1'b0;
      exp_q.delete();
      exp_status = ST_LOAD;
      strobes    = 0;
      @(negedge clock);
      check("rst_wr_en", 32'(out_pmem_wr_en), 32'd0);
      check("rst_wr_addr", 32'(out_pmem_wr_addr), 32'h000);
      check("rst_wr_word", 32'(out_pmem_wr_word), 32'h0000);
      check("rst_core_reset", 32'(out_core_reset), 32'd1);
      check("rst_done", 32'(out_done), 32'd0);
      check("rst_error", 32'(out_error), 32'd0);
      check("rst_ready", 32'(out_byte_ready), 32'd1);
      chk_en = 1'b1;
      @(posedge clock);
      #2;
   endtask

   task automatic settle_and_drain();
      repeat (3) begin
         @(posedge clock);
         #2;
      end
      check("writes_outstanding", 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clock) begin
      logic [27:0] e;
      if (chk_en) begin
         check("ready", 32'(out_byte_ready), 32'(exp_status == ST_LOAD));
         check("done", 32'(out_done), 32'(exp_status == ST_RUN));
         check("error", 32'(out_error), 32'(exp_status == ST_ERR));
         check("core_reset", 32'(out_core_reset), 32'(exp_status != ST_RUN));
         if (out_pmem_wr_en) begin
            strobes++;
            last_addr = out_pmem_wr_addr;
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(out_pmem_wr_addr), 32'(e[27:16]));
               check("wr_word", 32'(out_pmem_wr_word), 32'(e[15:0]));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Good two-word frame
      wq = '{16'h1234, 16'hABCD};
      build_frame(2, 1'b0);
      check("model_csum_a", 32'(model_csum), 32'h40);
      check("model_wr0", 32'(exp_q[0]), {4'h0, 12'h000, 16'h1234});
      check("model_wr1", 32'(exp_q[1]), {4'h0, 12'h002, 16'hABCD});
      send_bytes(frame_q.size(), 0);
      settle_and_drain();
      check("a_strobes", 32'(strobes), 32'd2);
      check("a_done", 32'(out_done), 32'd1);
      check("a_core_reset", 32'(out_core_reset), 32'd0);

      // Same frame, wrong checksum; extra bytes afterwards must be ignored
      do_reset();
      build_frame(2, 1'b1);
      check("model_csum_bad", 32'(frame_q[6]), 32'h41);
      send_bytes(frame_q.size(), 0);
      in_byte_valid = 1'b1;
      in_byte       = 8'h55;
      repeat (4) begin
         @(posedge clock);
         #2;
      end
      in_byte_valid = 1'b0;
      settle_and_drain();
      check("b_strobes", 32'(strobes), 32'd2);
      check("b_error", 32'(out_error), 32'd1);
      check("b_core_reset", 32'(out_core_reset), 32'd1);

      // Empty frame
      do_reset();
      wq.delete();
      build_frame(0, 1'b0);
      check("model_len_empty", 32'(frame_q.size()), 32'd3);
      send_bytes(frame_q.size(), 2);
      settle_and_drain();
      check("c_strobes", 32'(strobes), 32'd0);
      check("c_done", 32'(out_done), 32'd1);

      // Oversize count
      do_reset();
      build_frame(16'h0801, 1'b0);
      send_bytes(frame_q.size(), 0);
      settle_and_drain();
      check("d_strobes", 32'(strobes), 32'd0);
      check("d_error", 32'(out_error), 32'd1);

      // Three words with idle gaps between bytes
      do_reset();
      wq = '{16'h0102, 16'hA5A5, 16'hFFEE};
      build_frame(3, 1'b0);
      send_bytes(frame_q.size(), 5);
      settle_and_drain();
      check("e_strobes", 32'(strobes), 32'd3);
      check("e_last_addr", 32'(last_addr), 32'h004);

      // Partial frame aborted by reset, then a clean single-word frame
      do_reset();
      wq = '{16'h2211, 16'h4433};
      build_frame(2, 1'b0);
      send_bytes(5, 1);
      do_reset();
      wq = '{16'h00F0};
      build_frame(1, 1'b0);
      check("model_csum_f", 32'(model_csum), 32'hF0);
      send_bytes(frame_q.size(), 0);
      settle_and_drain();
      check("f_strobes", 32'(strobes), 32'd1);
      check("f_done", 32'(out_done), 32'd1);

      // Maximum-size frame
      do_reset();
      wq.delete();
      for (int i = 0; i < 2048; i++) wq.push_back(16'((i * 257) ^ 32'h5A3C));
      build_frame(2048, 1'b0);
      send_bytes(frame_q.size(), 0);
      settle_and_drain();
      check("g_strobes", 32'(strobes), 32'd2048);
      check("g_last_addr", 32'(last_addr), 32'hFFE);
      check("g_done", 32'(out_done), 32'd1);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
